// File: rtl/umtrx_tx_vita_demux_pkg.sv
// Shared constants for the TX VITA demux: stream field positions and FSM encoding.
package umtrx_tx_vita_demux_pkg;

    localparam int TDATA_W = 36;
    localparam int SOF_BIT = 32;
    localparam int EOF_BIT = 33;
    localparam int OCC_MSB = 35;
    localparam int SID_LSB = 0;
    localparam int SID_W   = 16;
    localparam int SEL_W   = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_DROP = 2'd2
    } demux_state_t;

endpackage

// File: rtl/umtrx_tx_vita_demux_if.sv
// Input stream plus NCHAN broadcast output streams of the TX VITA demux.
interface umtrx_tx_vita_demux_if #(parameter int NCHAN = 2);

    logic [35:0]         i_tdata;
    logic                i_tvalid;
    logic                i_tready;
    logic [36*NCHAN-1:0] o_tdata;
    logic [NCHAN-1:0]    o_tvalid;
    logic [NCHAN-1:0]    o_tready;

    modport master (
        output i_tdata, i_tvalid, o_tready,
        input  i_tready, o_tdata, o_tvalid
    );

    modport slave (
        input  i_tdata, i_tvalid, o_tready,
        output i_tready, o_tdata, o_tvalid
    );

endinterface

// File: rtl/setting_reg.sv
// Settings-bus register: latches data when the strobe hits its address.
module setting_reg #(
    parameter int          my_addr  = 0,
    parameter int          awidth   = 8,
    parameter int          width    = 32,
    parameter logic [31:0] at_reset = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              strobe,
    input  logic [awidth-1:0] addr,
    input  logic [width-1:0]  in,
    output logic [width-1:0]  out
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out <= at_reset[width-1:0];
        else if (strobe && (addr == awidth'(my_addr)))
            out <= in;
    end

endmodule

// File: rtl/umtrx_sat_counter.sv
// 16-bit event counter that sticks at all-ones; synchronous clear beats increment.
module umtrx_sat_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != 16'hFFFF))
            count <= count + 16'd1;
    end

endmodule

// File: rtl/umtrx_tx_vita_demux.sv
// Routes whole VITA packets from one input stream to one of NCHAN TX chains by SID.
//
//   state  | meaning
//   S_IDLE | between packets; SOF word decides forward / drop, stray words are frame errors
//   S_FWD  | passing the rest of a packet to chain sel with ready/valid straight through
//   S_DROP | swallowing the rest of an unroutable packet at one word per cycle
module umtrx_tx_vita_demux
    import umtrx_tx_vita_demux_pkg::*;
#(
    parameter int BASE  = 0,
    parameter int NCHAN = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_stb,
    input  logic [7:0]           set_addr,
    input  logic [31:0]          set_data,
    umtrx_tx_vita_demux_if.slave bus,
    output logic [15:0]          drop_count,
    output logic [15:0]          frame_errs
);

    demux_state_t     st, nxt;
    logic [SEL_W-1:0] sel, sel_nxt, hit_idx;
    logic [19:0]      cfg;
    logic [15:0]      sid_base, sid;
    logic [3:0]       mask;
    logic             hit, sof, eof, tr_hit, tr_sel, rdy;
    logic             drop_inc, ferr_inc, cnt_clr;
    logic [NCHAN-1:0] vld;

    setting_reg #(.my_addr(BASE), .awidth(8), .width(20), .at_reset(32'd0)) u_cfg (
        .clk(clk), .rst(rst), .strobe(set_stb), .addr(set_addr),
        .in(set_data[19:0]), .out(cfg)
    );

    assign sid_base = cfg[15:0];
    assign mask     = cfg[19:16];
    assign cnt_clr  = set_stb && (set_addr == 8'(BASE + 1));
    assign sid      = bus.i_tdata[SID_LSB +: SID_W];
    assign sof      = bus.i_tdata[SOF_BIT];
    assign eof      = bus.i_tdata[EOF_BIT];

    // Bits above the routing fields and enables of non-existent chains are don't-care.
    logic unused_ok;
    assign unused_ok = &{1'b0, mask, set_data[31:20], bus.i_tdata[OCC_MSB -: 2]};

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        tr_hit  = 1'b0;
        tr_sel  = 1'b0;
        for (int k = NCHAN - 1; k >= 0; k--) begin
            if ((sid == sid_base + 16'(k)) && mask[k]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(k);
            end
        end
        for (int k = 0; k < NCHAN; k++) begin
            if (hit_idx == SEL_W'(k)) tr_hit = bus.o_tready[k];
            if (sel == SEL_W'(k))     tr_sel = bus.o_tready[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st  <= S_IDLE;
            sel <= '0;
        end else begin
            st  <= nxt;
            sel <= sel_nxt;
        end
    end

    always_comb begin
        nxt      = st;
        sel_nxt  = sel;
        rdy      = 1'b0;
        vld      = '0;
        drop_inc = 1'b0;
        ferr_inc = 1'b0;
        case (st)
            S_IDLE: begin
                if (!sof) begin
                    rdy      = 1'b1;
                    ferr_inc = bus.i_tvalid;
                end else if (hit) begin
                    for (int k = 0; k < NCHAN; k++)
                        if (hit_idx == SEL_W'(k)) vld[k] = bus.i_tvalid;
                    rdy = tr_hit;
                    if (bus.i_tvalid && tr_hit) begin
                        sel_nxt = hit_idx;
                        nxt     = eof ? S_IDLE : S_FWD;
                    end
                end else begin
                    rdy      = 1'b1;
                    drop_inc = bus.i_tvalid;
                    if (bus.i_tvalid) nxt = eof ? S_IDLE : S_DROP;
                end
            end
            S_FWD: begin
                for (int k = 0; k < NCHAN; k++)
                    if (sel == SEL_W'(k)) vld[k] = bus.i_tvalid;
                rdy = tr_sel;
                if (bus.i_tvalid && tr_sel && eof) nxt = S_IDLE;
            end
            S_DROP: begin
                rdy = 1'b1;
                if (bus.i_tvalid && eof) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
        rdy = rdy & ~rst;
    end

    assign bus.i_tready = rdy;
    assign bus.o_tvalid = vld;
    assign bus.o_tdata  = {NCHAN{bus.i_tdata}};

    umtrx_sat_counter u_drop (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(drop_inc), .count(drop_count)
    );

    umtrx_sat_counter u_ferr (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(ferr_inc), .count(frame_errs)
    );

endmodule
